rv32i_core_datapath: RTL and testbench
======================================

# rv32i_core_datapath

Datapath of the RV32I single-cycle core: PC register, 32×32 register file, immediate extender, operand muxes, ALU and write-back mux. The control unit drives all control inputs. Instruction memory supplies `instr` for the current `pc`, and data memory consumes `alu_result`/`write_data` and returns `read_data`. A debug read port exposes any architectural register to benches and top-level logic.

## Interface
No parameters (XLEN fixed at 32).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: reset is synchronous and active-high; clears PC and the register file.
- `result_src` in 2: write-back select (00 ALU, 01 read_data, 10 PC+4, 11 imm_ext).
- `pc_src` in 1: next PC select (0 PC+4, 1 PC+imm_ext).
- `alu_src` in 1: ALU B select (0 rs2 data, 1 imm_ext).
- `alu_src_a` in 1: ALU A select (0 rs1 data, 1 PC).
- `reg_write` in 1: register-file write enable.
- `imm_src` in 3: immediate format select.
- `alu_control` in 4: ALU operation.
- `instr` in 32: current instruction.
- `read_data` in 32: data-memory load data.
- `zero`, `carry`, `overflow`, `negative` out 1 each: ALU flags.
- `pc` out 32: current PC.
- `alu_result` out 32: ALU output (data-memory address).
- `write_data` out 32: rs2 read data (store data).
- `dbg_reg_addr` in 5: debug register index.
- `dbg_reg_data` out 32: combinational contents of register `dbg_reg_addr`; 0 for index 0.

## Operation
- Field decode: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
- Register file: two combinational reads plus one debug read. x0 reads 0 and ignores writes. Reads return the old value within the write cycle; there is no bypass.
- imm_ext by `imm_src`:
  - 0: I-type, sext instr[31:20].
  - 1: S-type, sext {[31:25],[11:7]}.
  - 2: B-type, sext {[31],[7],[30:25],[11:8],0}.
  - 3: J-type, sext {[31],[19:12],[20],[30:21],0}.
  - 4: U-type, {[31:12],12'b0}.
  - 5–7: 0.
- srcA = alu_src_a ? pc : rs1_data. srcB = alu_src ? imm_ext : rs2_data.
- ALU by `alu_control`:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA. Shift amount is srcB[4:0].
  - Other codes: result 0.
- Flags:
  - zero = (result==0); negative = result[31].
  - carry = carry-out of A+B (ADD) or A+~B+1 (SUB; 1 means no borrow). 0 for other ops.
  - overflow = signed overflow of ADD/SUB. 0 for other ops.
- Write-back value per `result_src` table; written to rd when reg_write=1.
- pc_plus4 = pc+4. pc_target = pc+imm_ext, which is the JAL/branch target. Next PC = pc_src ? pc_target : pc_plus4.
- All arithmetic is modulo 2^32; PC wraps 0xFFFFFFFC→0.

## Timing
- Combinational from inputs/state to every output; no pipeline stage. An instruction completes in one cycle.
- On rising edge with reset=0: pc ← next PC; if reg_write and rd≠0, reg[rd] ← result.
- On rising edge with reset=1: pc ← 0 and all registers ← 0. Reset wins over reg_write and pc_src.
- Reset values: pc=0; dbg_reg_data=0 for all indices. Other outputs follow combinationally from instr/read_data with all registers 0.
- Reset asserted mid-program: takes effect at the next edge; the in-flight write is discarded.
- After a write edge, the written value is visible on rs reads and on the debug port immediately (same cycle, combinational).

## Structure
- Shared package `rv32i_pkg`: ALU op codes, imm_src codes, result_src codes.
- One natural sub-module: `rv32i_alu` (ALU plus flags).
- Register file, immediate extender and muxes stay inline.
- Target size 150–300 lines of RTL.

## Test plan
- Reset 3 cycles → pc=0, dbg reads of x1..x31 = 0. Release reset → pc increments by 4 per cycle with pc_src=0.
- Run `addi x1,x0,5` (0x00500093, ADD, imm I, alu_src=1) → alu_result=5, x1=5. Then `addi x2,x1,7` (0x00708113) → 12, x2=12. Then `add x3,x1,x2` (0x002081B3, alu_src=0, imm_src=5) → 17, x3=17.
- Write attempt to x0 (0x00500013, reg_write=1) → dbg x0 = 0. SUB with x1=5, x2=5 → result 0, zero=1, carry=1.
- ADD 0x7FFFFFFF+1 → 0x80000000, overflow=1, negative=1. SLT −1<1 → 1; SLTU of the same operands → 0. SRA 0x80000000 by 4 → 0xF8000000.
- AUIPC-style (alu_src_a=1, imm U 0x00001000) at pc=0x10 → 0x1010. result_src=10 writes pc+4. pc_src=1 with B-imm −8 at pc=0x20 → next pc=0x18.
- Load path: result_src=01, read_data=0xDEADBEEF → rd holds 0xDEADBEEF. Assert reset mid-sequence → pc=0, registers 0 next edge.

Source files
------------

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared encodings for the RV32I single-cycle datapath:
//               ALU operation codes, immediate-format selects and
//               write-back source selects.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    localparam int unsigned c_XLEN = 32;

    // ALU operation codes (alu_control)
    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b0001;
    localparam logic [3:0] c_ALU_AND  = 4'b0010;
    localparam logic [3:0] c_ALU_OR   = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SLT  = 4'b0101;
    localparam logic [3:0] c_ALU_SLTU = 4'b0110;
    localparam logic [3:0] c_ALU_SLL  = 4'b0111;
    localparam logic [3:0] c_ALU_SRL  = 4'b1000;
    localparam logic [3:0] c_ALU_SRA  = 4'b1001;

    // Immediate format selects (imm_src)
    localparam logic [2:0] c_IMM_I = 3'd0;
    localparam logic [2:0] c_IMM_S = 3'd1;
    localparam logic [2:0] c_IMM_B = 3'd2;
    localparam logic [2:0] c_IMM_J = 3'd3;
    localparam logic [2:0] c_IMM_U = 3'd4;

    // Write-back source selects (result_src)
    localparam logic [1:0] c_RES_ALU  = 2'b00;
    localparam logic [1:0] c_RES_MEM  = 2'b01;
    localparam logic [1:0] c_RES_PC4  = 2'b10;
    localparam logic [1:0] c_RES_IMM  = 2'b11;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/rv32i_alu.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_alu
// Description : 32-bit RV32I ALU with zero/carry/overflow/negative flags.
//               Ports: i_a, i_b (operands), i_op (operation code),
//               o_result, o_zero, o_carry, o_overflow, o_negative.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_op,
    output logic [31:0] o_result,
    output logic        o_zero,
    output logic        o_carry,
    output logic        o_overflow,
    output logic        o_negative
);

    // 33-bit adders expose the carry-out; subtraction is A + ~B + 1 so a
    // carry of 1 means "no borrow".
    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [4:0]  w_shamt;
    logic        w_ovf_add;
    logic        w_ovf_sub;

    assign w_sum     = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff    = {1'b0, i_a} + {1'b0, ~i_b} + 33'd1;
    assign w_shamt   = i_b[4:0];
    assign w_ovf_add = (i_a[31] == i_b[31]) && (w_sum[31]  != i_a[31]);
    assign w_ovf_sub = (i_a[31] != i_b[31]) && (w_diff[31] != i_a[31]);

    always_comb begin
        o_result   = 32'd0;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        case (i_op)
            c_ALU_ADD: begin
                o_result   = w_sum[31:0];
                o_carry    = w_sum[32];
                o_overflow = w_ovf_add;
            end
            c_ALU_SUB: begin
                o_result   = w_diff[31:0];
                o_carry    = w_diff[32];
                o_overflow = w_ovf_sub;
            end
            c_ALU_AND:  o_result = i_a & i_b;
            c_ALU_OR:   o_result = i_a | i_b;
            c_ALU_XOR:  o_result = i_a ^ i_b;
            c_ALU_SLT:  o_result = {31'd0, $signed(i_a) < $signed(i_b)};
            c_ALU_SLTU: o_result = {31'd0, i_a < i_b};
            c_ALU_SLL:  o_result = i_a << w_shamt;
            c_ALU_SRL:  o_result = i_a >> w_shamt;
            c_ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            default:    o_result = 32'd0;
        endcase
    end

    assign o_zero     = (o_result == 32'd0);
    assign o_negative = o_result[31];

endmodule : rv32i_alu
`default_nettype wire

// File: rtl/rv32i_core_datapath.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_core_datapath
// Description : Single-cycle RV32I datapath: PC register, 32x32 register
//               file, immediate extender, operand muxes, ALU, write-back mux.
//               Inputs : clk, reset (sync, active-high), result_src, pc_src,
//                        alu_src, alu_src_a, reg_write, imm_src, alu_control,
//                        instr, read_data, dbg_reg_addr.
//               Outputs: zero, carry, overflow, negative, pc, alu_result,
//                        write_data, dbg_reg_data.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_core_datapath
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  result_src,
    input  logic        pc_src,
    input  logic        alu_src,
    input  logic        alu_src_a,
    input  logic        reg_write,
    input  logic [2:0]  imm_src,
    input  logic [3:0]  alu_control,
    input  logic [31:0] instr,
    input  logic [31:0] read_data,
    output logic        zero,
    output logic        carry,
    output logic        overflow,
    output logic        negative,
    output logic [31:0] pc,
    output logic [31:0] alu_result,
    output logic [31:0] write_data,
    input  logic [4:0]  dbg_reg_addr,
    output logic [31:0] dbg_reg_data
);

    logic [31:0] r_pc;
    logic [31:0] r_regs [0:31];

    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_rs1_data;
    logic [31:0] w_rs2_data;
    logic [31:0] w_imm_ext;
    logic [31:0] w_src_a;
    logic [31:0] w_src_b;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_target;
    logic [31:0] w_pc_next;
    logic [31:0] w_result;
    logic [6:0]  w_unused_opcode;

    assign w_rs1 = instr[19:15];
    assign w_rs2 = instr[24:20];
    assign w_rd  = instr[11:7];

    // Opcode is decoded by the control unit, not here.
    assign w_unused_opcode = instr[6:0];

    // Register file reads: x0 is hard-wired to zero, no write bypass.
    assign w_rs1_data   = (w_rs1 == 5'd0)        ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_data   = (w_rs2 == 5'd0)        ? 32'd0 : r_regs[w_rs2];
    assign dbg_reg_data = (dbg_reg_addr == 5'd0) ? 32'd0 : r_regs[dbg_reg_addr];

    // Immediate extender
    always_comb begin
        w_imm_ext = 32'd0;
        case (imm_src)
            c_IMM_I: w_imm_ext = {{20{instr[31]}}, instr[31:20]};
            c_IMM_S: w_imm_ext = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            c_IMM_B: w_imm_ext = {{20{instr[31]}}, instr[7], instr[30:25],
                                  instr[11:8], 1'b0};
            c_IMM_J: w_imm_ext = {{12{instr[31]}}, instr[19:12], instr[20],
                                  instr[30:21], 1'b0};
            c_IMM_U: w_imm_ext = {instr[31:12], 12'd0};
            default: w_imm_ext = 32'd0;
        endcase
    end

    assign w_src_a = alu_src_a ? r_pc : w_rs1_data;
    assign w_src_b = alu_src   ? w_imm_ext : w_rs2_data;

    rv32i_alu u_alu (
        .i_a        (w_src_a),
        .i_b        (w_src_b),
        .i_op       (alu_control),
        .o_result   (alu_result),
        .o_zero     (zero),
        .o_carry    (carry),
        .o_overflow (overflow),
        .o_negative (negative)
    );

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_pc_target = r_pc + w_imm_ext;
    assign w_pc_next   = pc_src ? w_pc_target : w_pc_plus4;

    always_comb begin
        w_result = alu_result;
        case (result_src)
            c_RES_ALU: w_result = alu_result;
            c_RES_MEM: w_result = read_data;
            c_RES_PC4: w_result = w_pc_plus4;
            c_RES_IMM: w_result = w_imm_ext;
            default:   w_result = alu_result;
        endcase
    end

    // State update: reset overrides any pending register write or branch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= 32'd0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            r_pc <= w_pc_next;
            if (reg_write && (w_rd != 5'd0)) begin
                r_regs[w_rd] <= w_result;
            end
        end
    end

    assign pc         = r_pc;
    assign write_data = w_rs2_data;

endmodule : rv32i_core_datapath
`default_nettype wire

// File: tb/tb_rv32i_core_datapath.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_core_datapath
// Description : Directed self-checking bench for rv32i_core_datapath with
//               hand-computed expected values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_core_datapath;

    logic        clk;
    logic        reset;
    logic [1:0]  result_src;
    logic        pc_src;
    logic        alu_src;
    logic        alu_src_a;
    logic        reg_write;
    logic [2:0]  imm_src;
    logic [3:0]  alu_control;
    logic [31:0] instr;
    logic [31:0] read_data;
    logic        zero;
    logic        carry;
    logic        overflow;
    logic        negative;
    logic [31:0] pc;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  dbg_reg_addr;
    logic [31:0] dbg_reg_data;

    int n_checks = 0;
    int n_fail   = 0;

    rv32i_core_datapath dut (
        .clk          (clk),
        .reset        (reset),
        .result_src   (result_src),
        .pc_src       (pc_src),
        .alu_src      (alu_src),
        .alu_src_a    (alu_src_a),
        .reg_write    (reg_write),
        .imm_src      (imm_src),
        .alu_control  (alu_control),
        .instr        (instr),
        .read_data    (read_data),
        .zero         (zero),
        .carry        (carry),
        .overflow     (overflow),
        .negative     (negative),
        .pc           (pc),
        .alu_result   (alu_result),
        .write_data   (write_data),
        .dbg_reg_addr (dbg_reg_addr),
        .dbg_reg_data (dbg_reg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction's worth of control, then let it settle.
    task automatic drive(input logic [31:0] ins, input logic [3:0] op,
                         input logic [2:0] isrc, input logic bsel, input logic asel,
                         input logic [1:0] rsrc, input logic we, input logic psel);
        instr       = ins;
        alu_control = op;
        imm_src     = isrc;
        alu_src     = bsel;
        alu_src_a   = asel;
        result_src  = rsrc;
        reg_write   = we;
        pc_src      = psel;
        #1;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        dbg_reg_addr = idx;
        #1;
        check(tag, dbg_reg_data, exp);
    endtask

    initial begin
        reset = 1'b1; read_data = 32'd0; dbg_reg_addr = 5'd0;
        drive(32'd0, 4'd0, 3'd5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (3) step();
        check("reset_pc", pc, 32'd0);
        for (int i = 1; i < 32; i++) check_reg("reset_reg", 5'(i), 32'd0);

        // Free-running PC
        reset = 1'b0;
        step(); check("pc_inc4", pc, 32'd4);
        step(); check("pc_inc8", pc, 32'd8);

        // addi x1,x0,5
        drive(32'h00500093, 4'b0000, 3'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        check("addi1_res", alu_result, 32'd5);
        step(); check_reg("x1", 5'd1, 32'd5);
        check("pc_after_addi", pc, 32'd12);
        // addi x2,x1,7
        drive(32'h00708113, 4'b0000, 3'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        check("addi2_res", alu_result, 32'd12);
        step(); check_reg("x2", 5'd2, 32'd12);
        // add x3,x1,x2
        drive(32'h002081B3, 4'b0000, 3'd5, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        check("add_res", alu_result, 32'd17);
        check("add_wdata", write_data, 32'd12);
        step(); check_reg("x3", 5'd3, 32'd17);
        // addi x0,x0,5 must not stick
        drive(32'h00500013, 4'b0000, 3'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        step(); check_reg("x0", 5'd0, 32'd0);

        // addi x2,x0,5 then sub x4,x1,x2 (5-5)
        drive(32'h00500113, 4'b0000, 3'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        step();
        drive(32'h40208233, 4'b0001, 3'd5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        check("sub_res", alu_result, 32'd0);
        check("sub_zero", {31'd0, zero}, 32'd1);
        check("sub_carry", {31'd0, carry}, 32'd1);
        check("sub_ovf", {31'd0, overflow}, 32'd0);
        step();

        // lw x5 <- 0x7FFFFFFF, then addi x6,x5,1
        read_data = 32'h7FFFFFFF;
        drive(32'h00002283, 4'b0000, 3'd0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        step(); check_reg("x5_load", 5'd5, 32'h7FFFFFFF);
        drive(32'h00128313, 4'b0000, 3'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        check("ovf_res", alu_result, 32'h80000000);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_neg", {31'd0, negative}, 32'd1);
        check("ovf_carry", {31'd0, carry}, 32'd0);
        check("ovf_zero", {31'd0, zero}, 32'd0);
        step(); check_reg("x6", 5'd6, 32'h80000000);

        // x7 = -1; slti/sltiu x8,x7,1
        drive(32'hFFF00393, 4'b0000, 3'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        step(); check_reg("x7", 5'd7, 32'hFFFFFFFF);
        drive(32'h0013A413, 4'b0101, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        check("slt", alu_result, 32'd1);
        check("slt_carry", {31'd0, carry}, 32'd0);
        drive(32'h0013A413, 4'b0110, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        check("sltu", alu_result, 32'd0);
        check("sltu_zero", {31'd0, zero}, 32'd1);
        step();

        // srai x9,x6,4
        drive(32'h40435493, 4'b1001, 3'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        check("sra", alu_result, 32'hF8000000);
        step(); check_reg("x9", 5'd9, 32'hF8000000);

        // lw x10 <- 0xDEADBEEF
        read_data = 32'hDEADBEEF;
        drive(32'h00002503, 4'b0000, 3'd0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0);
        step(); check_reg("x10_load", 5'd10, 32'hDEADBEEF);

        // Reset in the same cycle as a write and a taken branch
        reset = 1'b1;
        drive(32'h00700593, 4'b0000, 3'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
        step();
        check("rst_mid_pc", pc, 32'd0);
        check_reg("rst_mid_x1", 5'd1, 32'd0);
        check_reg("rst_mid_x10", 5'd10, 32'd0);
        check_reg("rst_mid_x11", 5'd11, 32'd0);

        reset = 1'b0;
        drive(32'd0, 4'b0000, 3'd5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (4) step();
        check("pc_0x10", pc, 32'h10);

        // auipc x10,1 at pc=0x10
        drive(32'h00001517, 4'b0000, 3'd4, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0);
        check("auipc", alu_result, 32'h1010);
        step(); check_reg("x10_auipc", 5'd10, 32'h1010);
        // jal x1,0 link value at pc=0x14 (no redirect)
        drive(32'h000000EF, 4'b0000, 3'd3, 1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
        step(); check_reg("x1_link", 5'd1, 32'h18);
        drive(32'd0, 4'b0000, 3'd5, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        repeat (2) step();
        check("pc_0x20", pc, 32'h20);

        // Branch with B-imm -8 at pc=0x20
        drive(32'hFE000CE3, 4'b0001, 3'd2, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        step(); check("branch_pc", pc, 32'h18);

        // jal x0,-28 at pc=0x18 -> 0xFFFFFFFC, then wrap to 0
        drive(32'hFE5FF06F, 4'b0000, 3'd3, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        step(); check("jal_pc", pc, 32'hFFFFFFFC);
        // lui x12,0xABCDE via imm write-back while PC wraps
        drive(32'hABCDE637, 4'b0000, 3'd4, 1'b1, 1'b0, 2'b11, 1'b1, 1'b0);
        step(); check("pc_wrap", pc, 32'd0);
        check_reg("x12_lui", 5'd12, 32'hABCDE000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_rv32i_core_datapath
`default_nettype wire
